// File: rtl/cpu_core.sv
// Single-cycle 32-bit MIPS-style execution core: decode, 32x32 register file,
// ALU and write-back on the rising clock edge. No fetch, PC or data memory.
module cpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  logic [31:0] regs_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, opb, imm_sext, imm_zext;
  logic [31:0] wdata_d;
  logic [4:0]  waddr_d;
  logic        we_d;
  alu_op_e     alu_op;

  assign op       = Inst[31:26];
  assign rs       = Inst[25:21];
  assign rt       = Inst[20:16];
  assign rd       = Inst[15:11];
  assign shamt    = Inst[10:6];
  assign funct    = Inst[5:0];
  assign imm      = Inst[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  assign rs_val   = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : regs_q[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

  // Unlisted opcode/funct (including any X-bearing pattern) falls to the
  // default arms and leaves we_d low, so nothing is written.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = rd;
    alu_op  = ALU_ADD;
    opb     = rt_val;
    case (op)
      6'b000000: begin
        we_d = 1'b1;
        case (funct)
          6'b100000: alu_op = ALU_ADD;
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b100110: alu_op = ALU_XOR;
          6'b100111: alu_op = ALU_NOR;
          6'b101010: alu_op = ALU_SLT;
          6'b101011: alu_op = ALU_SLTU;
          6'b000000: alu_op = ALU_SLL;
          6'b000010: alu_op = ALU_SRL;
          6'b000011: alu_op = ALU_SRA;
          default:   we_d   = 1'b0;
        endcase
      end
      6'b010000: begin we_d = 1'b1; waddr_d = rt; alu_op = ALU_ADD; opb = imm_sext; end
      6'b010001: begin we_d = 1'b1; waddr_d = rt; alu_op = ALU_AND; opb = imm_zext; end
      6'b010010: begin we_d = 1'b1; waddr_d = rt; alu_op = ALU_OR;  opb = imm_zext; end
      6'b010011: begin we_d = 1'b1; waddr_d = rt; alu_op = ALU_SLT; opb = imm_sext; end
      default:   we_d = 1'b0;
    endcase
  end

  always_comb begin
    wdata_d = '0;
    case (alu_op)
      ALU_ADD:  wdata_d = rs_val + opb;
      ALU_SUB:  wdata_d = rs_val - opb;
      ALU_AND:  wdata_d = rs_val & opb;
      ALU_OR:   wdata_d = rs_val | opb;
      ALU_XOR:  wdata_d = rs_val ^ opb;
      ALU_NOR:  wdata_d = ~(rs_val | opb);
      ALU_SLT:  wdata_d = {31'b0, $signed(rs_val) < $signed(opb)};
      ALU_SLTU: wdata_d = {31'b0, rs_val < opb};
      ALU_SLL:  wdata_d = rt_val << shamt;
      ALU_SRL:  wdata_d = rt_val >> shamt;
      ALU_SRA:  wdata_d = $unsigned($signed(rt_val) >>> shamt);
      default:  wdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_d && (waddr_d != 5'd0)) begin
      regs_q[waddr_d] <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed literal checks plus randomized instructions
// compared against an architectural register-file model after every edge.
`timescale 1ns/10ps
module tb_cpu_core;

  logic        clk;
  logic        reset;
  logic [31:0] Inst;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [31:0] m [32];

  cpu_core dut (
    .clk      (clk),
    .reset    (reset),
    .Inst     (Inst),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    logic [4:0] a, b, c, d;
    a = 5'(rs); b = 5'(rt); c = 5'(rd); d = 5'(sh);
    return {6'b000000, a, b, c, d, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                        input int rt, input logic [15:0] imm);
    logic [4:0] a, b;
    a = 5'(rs); b = 5'(rt);
    return {op, a, b, imm};
  endfunction

  // Architectural effect of one instruction on the model register file.
  task automatic model_exec(input logic [31:0] ins);
    int unsigned s, t, sh, dst;
    int signed ss, st, si;
    logic [31:0] r;
    bit wr;
    s   = m[ins[25:21]];
    t   = m[ins[20:16]];
    sh  = ins[10:6];
    ss  = int'(s);
    st  = int'(t);
    si  = int'({{16{ins[15]}}, ins[15:0]});
    wr  = 1'b1;
    dst = ins[15:11];
    r   = 32'h0;
    if (ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'h20: r = s + t;
        6'h22: r = s - t;
        6'h24: r = s & t;
        6'h25: r = s | t;
        6'h26: r = s ^ t;
        6'h27: r = ~(s | t);
        6'h2A: r = (ss < st) ? 1 : 0;
        6'h2B: r = (s < t) ? 1 : 0;
        6'h00: r = t << sh;
        6'h02: r = t >> sh;
        6'h03: r = (sh == 0) ? t : ((t >> sh) | (t[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0));
        default: wr = 1'b0;
      endcase
    end else begin
      dst = ins[20:16];
      case (ins[31:26])
        6'h10: r = s + 32'(si);
        6'h11: r = s & {16'h0, ins[15:0]};
        6'h12: r = s | {16'h0, ins[15:0]};
        6'h13: r = (ss < si) ? 1 : 0;
        default: wr = 1'b0;
      endcase
    end
    if (wr && dst != 0) m[dst] = r;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic check_reg(input string name, input int idx, input logic [31:0] exp);
    dbg_addr = 5'(idx);
    #0.1;
    check($sformatf("%s r%0d", name, idx), dbg_data, exp);
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 32; i++) check_reg(name, i, m[i]);
  endtask

  // Present ins during the low phase, clock it, then compare the whole file.
  task automatic exec(input logic [31:0] ins);
    @(negedge clk);
    Inst = ins;
    @(posedge clk);
    model_exec(ins);
    #0.5;
    sweep("model");
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    int unsigned k, rs, rt, rd;
    logic [15:0] imm;
    k  = $urandom_range(0, 19);
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    rd = $urandom_range(0, 7);
    case ($urandom_range(0, 3))
      0: imm = 16'($urandom);
      1: imm = 16'hFFFF;
      2: imm = 16'h8000;
      default: imm = 16'($urandom_range(0, 4));
    endcase
    if (k < 11) return rtype(rs, rt, rd, $urandom_range(0, 31), fns[k]);
    if (k < 15) return itype(6'(6'h10 + (k - 11)), rs, rt, imm);
    if (k < 17) return rtype(rs, rt, rd, 0, 6'($urandom_range(4, 31)));
    if (k < 19) return itype(6'($urandom_range(20, 63)), rs, rt, imm);
    return 32'($urandom);
  endfunction

  initial begin
    reset = 1'b0;
    Inst = 32'h0;
    dbg_addr = 5'd0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    exec(32'h0000_0820);            check_reg("add_zero", 1, 32'h0000_0000);
    exec(32'h4001_0001);            check_reg("addi_1", 1, 32'h0000_0001);
    exec(32'h0021_0820);            check_reg("add_dep", 1, 32'h0000_0002);
    exec(itype(6'h10, 0, 2, 16'hFFFF)); check_reg("addi_neg", 2, 32'hFFFF_FFFF);
    exec(rtype(0, 2, 3, 0, 6'h22)); check_reg("sub", 3, 32'h0000_0001);
    exec(rtype(2, 0, 4, 0, 6'h2A)); check_reg("slt", 4, 32'h0000_0001);
    exec(rtype(2, 0, 4, 0, 6'h2B)); check_reg("sltu", 4, 32'h0000_0000);
    exec(rtype(2, 2, 5, 0, 6'h20)); check_reg("add_wrap", 5, 32'hFFFF_FFFE);
    exec(itype(6'h10, 0, 0, 16'h0005)); check_reg("r0_write", 0, 32'h0000_0000);
    exec(itype(6'h3F, 0, 1, 16'h1234)); check_reg("bad_op", 1, 32'h0000_0002);
    exec(itype(6'h12, 0, 6, 16'h8000)); check_reg("ori", 6, 32'h0000_8000);
    exec(rtype(0, 6, 7, 16, 6'h00)); check_reg("sll", 7, 32'h8000_0000);
    exec(rtype(0, 7, 8, 4, 6'h03));  check_reg("sra", 8, 32'hF800_0000);
    exec(rtype(0, 7, 9, 4, 6'h02));  check_reg("srl", 9, 32'h0800_0000);
    exec(itype(6'h13, 2, 10, 16'h0000)); check_reg("slti", 10, 32'h0000_0001);
    exec(itype(6'h11, 2, 11, 16'h8001)); check_reg("andi", 11, 32'h0000_8001);
    exec(32'h0000_0000);             check_reg("nop", 1, 32'h0000_0002);

    // Asynchronous reset between edges, and no write while it is held.
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    check_reg("async_rst", 1, 32'h0000_0000);
    Inst = itype(6'h10, 0, 1, 16'h0007);
    @(posedge clk);
    #1;
    check_reg("rst_hold", 1, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    exec(itype(6'h10, 0, 1, 16'h0003)); check_reg("post_rst", 1, 32'h0000_0003);

    for (int n = 0; n < 400; n++) exec(rand_inst());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
